// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq_pkg
// Description : Shared constants for the sequential binary-to-BCD converter.
//               Holds the FSM state encoding and the double-dabble add-3
//               threshold/increment.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_seq_pkg;

    // FSM state encoding. Two bits wide so that stray encodings exist and
    // are explicitly steered back to IDLE by the top-level FSM.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;

    // A digit at or above this value would reach 10 or more after the
    // following left shift, so it is pre-corrected by adding 3.
    localparam logic [3:0] c_ADD3_THRESH = 4'd5;
    localparam logic [3:0] c_ADD3        = 4'd3;

endpackage : bin_to_bcd_seq_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Combinational double-dabble digit correction: if the 4-bit
//               digit is >= 5, add 3 (4-bit result, no carry out).
// Ports       : i_digit [3:0] - BCD digit before correction
//               o_digit [3:0] - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= c_ADD3_THRESH) ? (i_digit + c_ADD3) : i_digit;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//               input bit per clock, with start/busy/done handshake. The
//               result register is held until the next done pulse.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-high reset
//               start - request conversion of bin (sampled in IDLE only)
//               bin   - WIDTH-bit unsigned input, sampled on accept
//               busy  - conversion in progress
//               done  - one-cycle pulse, bcd carries the new result
//               bcd   - packed BCD result, digit 0 in [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int c_WORK_W = WIDTH + 4 * DIGITS;
    localparam int c_CNT_W  = $clog2(WIDTH + 1);

    // The digit field must be able to hold the largest binary input.
    if ((10 ** DIGITS) < (2 ** WIDTH)) begin : g_param_check
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    logic [1:0]            r_state_q, w_state_d;
    logic [c_WORK_W-1:0]   r_work_q,  w_work_d;
    logic [c_CNT_W-1:0]    r_cnt_q,   w_cnt_d;
    logic                  r_busy_q,  w_busy_d;
    logic                  r_done_q,  w_done_d;
    logic [4*DIGITS-1:0]   r_bcd_q,   w_bcd_d;

    logic [4*DIGITS-1:0]   w_adj_digits;
    logic [c_WORK_W-1:0]   w_shifted;

    // Per-digit add-3 correction on the upper (digit) field of the work reg.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (r_work_q[WIDTH + 4*i +: 4]),
            .o_digit (w_adj_digits[4*i +: 4])
        );
    end

    // Corrected digits concatenated with the binary field, shifted left by 1.
    assign w_shifted = {w_adj_digits[4*DIGITS-2:0], r_work_q[WIDTH-1:0], 1'b0};

    always_comb begin
        w_state_d = r_state_q;
        w_work_d  = r_work_q;
        w_cnt_d   = r_cnt_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        w_bcd_d   = r_bcd_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (start) begin
                    w_work_d  = {{(4*DIGITS){1'b0}}, bin};
                    w_cnt_d   = c_CNT_W'(WIDTH);
                    w_busy_d  = 1'b1;
                    w_state_d = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                w_work_d = w_shifted;
                w_cnt_d  = r_cnt_q - c_CNT_W'(1);
                // Last input bit shifted in on this edge: publish the result.
                if (r_cnt_q == c_CNT_W'(1)) begin
                    w_bcd_d   = w_shifted[c_WORK_W-1:WIDTH];
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = c_ST_IDLE;
                end
            end
            default: begin
                w_busy_d  = 1'b0;
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= c_ST_IDLE;
            r_work_q  <= '0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_bcd_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_work_q  <= w_work_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_bcd_q   <= w_bcd_d;
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign bcd  = r_bcd_q;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. Stimulus pushes the
//               expected BCD word into a queue; a monitor pops and compares
//               on every done pulse. Covers WIDTH=8/DIGITS=3 and
//               WIDTH=4/DIGITS=2 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin = 8'd0;
    logic        busy, done;
    logic [11:0] bcd;

    logic        start4 = 1'b0;
    logic [3:0]  bin4 = 4'd0;
    logic        busy4, done4;
    logic [7:0]  bcd4;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    logic [7:0]  exp4_q[$];

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4)
    );

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // ---------------- monitors ----------------
    int          busy_len = 0;
    logic [11:0] prev_bcd = '0;

    always @(negedge clk) begin
        if (rst) begin
            busy_len = 0;
        end else begin
            if (busy) busy_len++;
            if (!done) begin
                checks++;
                if (bcd !== prev_bcd) begin
                    errors++;
                    $display("FAIL bcd_hold: bcd changed to %h without done (was %h)", bcd, prev_bcd);
                end
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: bcd=%h, no result expected", bcd);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    if (bcd !== e) begin
                        errors++;
                        $display("FAIL bcd8: got %h required %h", bcd, e);
                    end
                end
                checks++;
                if (busy !== 1'b0 || busy_len != 8) begin
                    errors++;
                    $display("FAIL busy8: busy=%0b len=%0d required busy=0 len=8", busy, busy_len);
                end
                busy_len = 0;
            end
        end
        prev_bcd = bcd;
    end

    int busy_len4 = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_len4 = 0;
        end else begin
            if (busy4) busy_len4++;
            if (done4) begin
                checks++;
                if (exp4_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done4: bcd4=%h", bcd4);
                end else begin
                    logic [7:0] e4;
                    e4 = exp4_q.pop_front();
                    if (bcd4 !== e4) begin
                        errors++;
                        $display("FAIL bcd4: got %h required %h", bcd4, e4);
                    end
                end
                checks++;
                if (busy4 !== 1'b0 || busy_len4 != 4) begin
                    errors++;
                    $display("FAIL busy4: busy=%0b len=%0d required busy=0 len=4", busy4, busy_len4);
                end
                busy_len4 = 0;
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: busy=%0b still set, required 0", busy);
                return;
            end
        end
    endtask

    task automatic issue(input logic [7:0] v, input logic [11:0] e);
        wait_idle();
        start = 1'b1;
        bin   = v;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        bin   = 8'($urandom);   // post-accept changes must not matter
    endtask

    task automatic issue4(input logic [3:0] v, input logic [7:0] e);
        int n = 0;
        while (busy4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        start4 = 1'b1;
        bin4   = v;
        exp4_q.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        bin4   = 4'($urandom);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b bcd=%h required 0/0/000", name, busy, done, bcd);
        end
    endtask

    // Directed vectors with hand-computed BCD values.
    logic [7:0]  vin[10]  = '{8'd0, 8'd255, 8'd99, 8'd100, 8'd7, 8'd42,
                              8'd1, 8'd9, 8'd10, 8'd199};
    logic [11:0] vexp[10] = '{12'h000, 12'h255, 12'h099, 12'h100, 12'h007, 12'h042,
                              12'h001, 12'h009, 12'h010, 12'h199};

    initial begin
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Back-to-back directed conversions (start re-issued in done cycle).
        for (int i = 0; i < 10; i++) issue(vin[i], vexp[i]);

        // Start pulse in the middle of a conversion is ignored.
        issue(8'd200, 12'h200);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd5;
        @(negedge clk);
        start = 1'b0;

        // Exhaustive sweep against the arithmetic reference model.
        for (int v = 0; v < 256; v++) issue(8'(v), ref_bcd(v));
        wait_idle();
        @(negedge clk);

        // Reset in the middle of a conversion.
        issue(8'd150, 12'h150);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_zero("reset_abort");
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        issue(8'd128, 12'h128);
        wait_idle();
        @(negedge clk);

        // Narrow instance: WIDTH=4, DIGITS=2.
        issue4(4'd15, 8'h15);
        issue4(4'd0,  8'h00);
        issue4(4'd9,  8'h09);
        issue4(4'd10, 8'h10);

        // Drain both scoreboards, bounded.
        for (int n = 0; n < 100 && (exp_q.size() != 0 || exp4_q.size() != 0); n++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || exp4_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d/%0d results, required 0/0",
                     exp_q.size(), exp4_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
